// File: rtl/pio_irq_ctrl_if.sv
// Bus bundle between the PIO state machines/host and the shared IRQ flag controller.
// The master drives strobes and enables; the slave returns flags, stalls and the host interrupt.
interface pio_irq_ctrl_if #(
   parameter int unsigned NSM   = 4,
   parameter int unsigned NFLAG = 8
);
   localparam int unsigned IdxW = $clog2(NFLAG);

   logic [NSM-1:0]       sm_restart;
   logic [NSM-1:0]       sm_en;
   logic [NSM*NFLAG-1:0] sm_set;
   logic [NSM*NFLAG-1:0] sm_clr;
   logic [NSM-1:0]       sm_wait_req;
   logic [NSM*IdxW-1:0]  sm_wait_idx;
   logic [NFLAG-1:0]     host_clr;
   logic [NFLAG-1:0]     host_force;
   logic [3:0]           irq_en;
   logic [NFLAG-1:0]     irq_flags;
   logic [NSM-1:0]       sm_stall;
   logic                 irq_out;

   modport master (
      output sm_restart, sm_en, sm_set, sm_clr, sm_wait_req, sm_wait_idx,
      output host_clr, host_force, irq_en,
      input  irq_flags, sm_stall, irq_out
   );

   modport slave (
      input  sm_restart, sm_en, sm_set, sm_clr, sm_wait_req, sm_wait_idx,
      input  host_clr, host_force, irq_en,
      output irq_flags, sm_stall, irq_out
   );
endinterface

// File: rtl/pio_irq_ctrl.sv
// Shared PIO IRQ flag register with per-machine "IRQ WAIT" sequencing.
// Set strobes win over clears; a waiting machine stalls until its flag reads clear.
module pio_irq_ctrl #(
   parameter int unsigned NSM   = 4,
   parameter int unsigned NFLAG = 8
) (
   input logic           clk,
   input logic           reset,
   pio_irq_ctrl_if.slave pio_io
);
   localparam int unsigned IdxW = $clog2(NFLAG);

   typedef enum logic [1:0] {StIdle, StArm, StWait} wait_st_e;

   logic [NFLAG-1:0] set_all, clr_all;
   logic [NFLAG-1:0] flags_d, flags_q;
   logic             irq_d, irq_q;
   logic [NSM-1:0]   stall_d, stall_q;
   logic [NSM-1:0]   busy;
   wait_st_e         st_d [NSM];
   wait_st_e         st_q [NSM];
   logic [IdxW-1:0]  widx_d [NSM];
   logic [IdxW-1:0]  widx_q [NSM];

   always_comb begin
      set_all = pio_io.host_force;
      clr_all = pio_io.host_clr;
      for (int unsigned m = 0; m < NSM; m++) begin
         if (pio_io.sm_en[m]) begin
            set_all = set_all | pio_io.sm_set[m*NFLAG +: NFLAG];
            clr_all = clr_all | pio_io.sm_clr[m*NFLAG +: NFLAG];
         end
      end
      flags_d = (flags_q & ~clr_all) | set_all;
      irq_d   = |(flags_d[3:0] & pio_io.irq_en);
   end

   // A flag re-set in the cycle it reads clear keeps the waiter stalled.
   always_comb begin
      for (int unsigned m = 0; m < NSM; m++) begin
         st_d[m]    = st_q[m];
         widx_d[m]  = widx_q[m];
         stall_d[m] = stall_q[m];
         busy[m]    = flags_q[widx_q[m]] | set_all[widx_q[m]];
         if (pio_io.sm_restart[m]) begin
            st_d[m]    = StIdle;
            stall_d[m] = 1'b0;
         end else begin
            case (st_q[m])
               StIdle: begin
                  if (pio_io.sm_wait_req[m] && pio_io.sm_en[m]) begin
                     widx_d[m]  = pio_io.sm_wait_idx[m*IdxW +: IdxW];
                     st_d[m]    = StArm;
                     stall_d[m] = 1'b1;
                  end
               end
               StArm, StWait: begin
                  if (!busy[m]) begin
                     st_d[m]    = StIdle;
                     stall_d[m] = 1'b0;
                  end else begin
                     st_d[m] = StWait;
                  end
               end
               default: begin
                  st_d[m]    = StIdle;
                  stall_d[m] = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
         irq_q   <= 1'b0;
         stall_q <= '0;
         for (int unsigned m = 0; m < NSM; m++) begin
            st_q[m]   <= StIdle;
            widx_q[m] <= '0;
         end
      end else begin
         flags_q <= flags_d;
         irq_q   <= irq_d;
         stall_q <= stall_d;
         for (int unsigned m = 0; m < NSM; m++) begin
            st_q[m]   <= st_d[m];
            widx_q[m] <= widx_d[m];
         end
      end
   end

   assign pio_io.irq_flags = flags_q;
   assign pio_io.sm_stall  = stall_q;
   assign pio_io.irq_out   = irq_q;

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Directed bench for pio_irq_ctrl: flag merge priority, wait handshake timing,
// restart and reset abort, host interrupt gating.
module tb_pio_irq_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pio_irq_ctrl_if #(.NSM(4), .NFLAG(8)) bus ();

   pio_irq_ctrl #(.NSM(4), .NFLAG(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .pio_io (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drop every strobe; irq_en is left as is.
   task automatic quiet();
      bus.sm_restart  = '0;
      bus.sm_en       = '0;
      bus.sm_set      = '0;
      bus.sm_clr      = '0;
      bus.sm_wait_req = '0;
      bus.sm_wait_idx = '0;
      bus.host_clr    = '0;
      bus.host_force  = '0;
   endtask

   task automatic set_wait(input int m, input logic [7:0] set, input logic [2:0] idx);
      bus.sm_en[m]             = 1'b1;
      bus.sm_set[8*m +: 8]     = set;
      bus.sm_wait_req[m]       = 1'b1;
      bus.sm_wait_idx[3*m +: 3] = idx;
   endtask

   initial begin
      reset = 1'b1;
      bus.irq_en = 4'h0;
      quiet();
      tick();
      tick();
      chk("rst_flags", bus.irq_flags, 8'h00);
      chk("rst_stall", bus.sm_stall, 4'h0);
      chk("rst_irq", bus.irq_out, 1'b0);
      reset = 1'b0;

      // 1: sm0 sets flag 2
      bus.sm_en = 4'b0001; bus.sm_set[7:0] = 8'h04;
      tick(); quiet();
      chk("t1_flags", bus.irq_flags, 8'h04);
      chk("t1_stall", bus.sm_stall, 4'h0);
      // strobe without sm_en is ignored
      bus.sm_set[15:8] = 8'h80; bus.sm_clr[7:0] = 8'h04;
      tick(); quiet();
      chk("gated_flags", bus.irq_flags, 8'h04);
      bus.sm_en = 4'b0001; bus.sm_clr[7:0] = 8'h04;
      tick(); quiet();
      chk("t1_clr", bus.irq_flags, 8'h00);

      // 2: sm1 set+wait on flag 5, sm0 clears 4 clks later
      set_wait(1, 8'h20, 3'd5);
      tick(); quiet();
      chk("t2_stall_rise", bus.sm_stall, 4'b0010);
      chk("t2_flags", bus.irq_flags, 8'h20);
      tick(); tick(); tick();
      chk("t2_stall_hold", bus.sm_stall, 4'b0010);
      bus.sm_en = 4'b0001; bus.sm_clr[7:0] = 8'h20;
      tick(); quiet();
      chk("t2_flag_clr", bus.irq_flags, 8'h00);
      chk("t2_stall_clr1", bus.sm_stall, 4'b0010);
      tick();
      chk("t2_stall_fall", bus.sm_stall, 4'b0000);

      // 3: set wins over host clear, irq_out on the same edge
      bus.irq_en = 4'h1;
      bus.sm_en = 4'b0100; bus.sm_set[23:16] = 8'h01; bus.host_clr = 8'h01;
      tick(); quiet();
      chk("t3_flags", bus.irq_flags, 8'h01);
      chk("t3_irq", bus.irq_out, 1'b1);
      bus.host_clr = 8'h01;
      tick(); quiet();
      chk("t3_irq_off", bus.irq_out, 1'b0);
      bus.irq_en = 4'h0; bus.host_force = 8'h01;
      tick(); quiet();
      chk("t3_irq_masked", bus.irq_out, 1'b0);
      bus.host_clr = 8'h01;
      tick(); quiet();

      // 4: sm0 and sm3 wait on flag 1, one host clear releases both
      set_wait(0, 8'h02, 3'd1);
      set_wait(3, 8'h02, 3'd1);
      tick(); quiet();
      chk("t4_stall", bus.sm_stall, 4'b1001);
      tick();
      bus.host_clr = 8'h02;
      tick(); quiet();
      chk("t4_flags", bus.irq_flags, 8'h00);
      chk("t4_stall_clr1", bus.sm_stall, 4'b1001);
      tick();
      chk("t4_stall_fall", bus.sm_stall, 4'b0000);

      // re-set while the flag reads clear keeps the waiter stalled
      set_wait(1, 8'h40, 3'd6);
      tick(); quiet();
      tick();
      bus.host_clr = 8'h40; bus.host_force = 8'h40;
      tick(); quiet();
      chk("reset_win_flags", bus.irq_flags, 8'h40);
      bus.host_clr = 8'h40;
      tick(); quiet();
      chk("reclr_flags", bus.irq_flags, 8'h00);
      bus.host_force = 8'h40;
      tick(); quiet();
      chk("reforce_stall", bus.sm_stall, 4'b0010);
      chk("reforce_flags", bus.irq_flags, 8'h40);
      bus.host_clr = 8'h40;
      tick(); quiet();
      tick();
      chk("reforce_release", bus.sm_stall, 4'b0000);

      // 5: restart aborts sm1's wait on flag 4
      set_wait(1, 8'h10, 3'd4);
      tick(); quiet();
      tick();
      bus.sm_restart = 4'b0010;
      tick(); quiet();
      chk("t5_stall", bus.sm_stall, 4'b0000);
      chk("t5_flags", bus.irq_flags, 8'h10);
      // restart beats a new wait request in the same cycle
      set_wait(1, 8'h08, 3'd3);
      bus.sm_restart = 4'b0010;
      tick(); quiet();
      chk("t5_prio_stall", bus.sm_stall, 4'b0000);
      chk("t5_prio_flags", bus.irq_flags, 8'h18);
      bus.host_clr = 8'hFF;
      tick(); quiet();

      // wait without its set bit: flag stays clear, stall lasts one ARM cycle
      bus.sm_en = 4'b0001; bus.sm_wait_req = 4'b0001; bus.sm_wait_idx[2:0] = 3'd3;
      tick(); quiet();
      chk("noset_stall", bus.sm_stall, 4'b0001);
      chk("noset_flags", bus.irq_flags, 8'h00);
      tick();
      chk("noset_release", bus.sm_stall, 4'b0000);

      // 6: reset mid-wait
      set_wait(2, 8'h80, 3'd7);
      tick(); quiet();
      bus.host_force = 8'hFF; bus.irq_en = 4'hF;
      tick(); quiet();
      chk("t6_flags", bus.irq_flags, 8'hFF);
      chk("t6_irq", bus.irq_out, 1'b1);
      chk("t6_stall", bus.sm_stall, 4'b0100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_flags", bus.irq_flags, 8'h00);
      chk("t6_rst_stall", bus.sm_stall, 4'b0000);
      chk("t6_rst_irq", bus.irq_out, 1'b0);
      tick();
      chk("t6_post_stall", bus.sm_stall, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
